hermes_vc_buffer: RTL and testbench
===================================

// Module: hermes_vc_buffer
// PURPOSE
// - Multi-virtual-channel input buffer for a Hermes router port. One independent circular FIFO and packet FSM per VC.
// - Incoming flits are steered by rx_vc_i into their VC FIFO.
// - Each VC issues its own routing request and drives its own header/size/payload flit stream toward the crossbar.
// - Sits between the port's link receiver and the switch control/crossbar; replaces the single-channel buffer on VC-enabled ports.
// PARAMETERS
// - NUM_VC       2   number of virtual channels (>=1)
// - BUFFER_SIZE  8   flits per VC FIFO; power of 2, >=2
// - FLIT_SIZE    32  flit width in bits; >=20
// - VC_BITS      derived, $clog2(NUM_VC) (1 when NUM_VC==1); localparam
// PORTS
// - clk_i       in   1                    clock; all state updates on posedge
// - rst_ni      in   1                    synchronous, active-low reset
// - rx_i        in   1                    incoming flit valid
// - rx_vc_i     in   VC_BITS              VC of incoming flit; sampled with rx_i
// - data_i      in   FLIT_SIZE            incoming flit
// - credit_o    out  NUM_VC               per-VC credit: 1 = FIFO not full
// - req_o       out  NUM_VC               per-VC routing request
// - req_ack_i   in   NUM_VC               per-VC routing grant
// - data_av_o   out  NUM_VC               per-VC flit available at data_o
// - data_ack_i  in   NUM_VC               per-VC flit consumed
// - sending_o   out  NUM_VC               per-VC: packet active AND FIFO non-empty
// - data_o      out  NUM_VC x FLIT_SIZE   per-VC head flit, packed [NUM_VC-1:0][FLIT_SIZE-1:0]
// BEHAVIOUR
// - Reset: synchronous, active-low; on rst_ni==0 at posedge all FIFOs empty, pointers 0, FSMs INIT, counters 0.
//   Reset applies mid-packet too; buffered flits are discarded.
// - Values after reset: credit_o all 1, req_o/data_av_o/sending_o all 0. data_o is don't-care while the FIFO is empty.
// - Write: when rx_i && credit_o[rx_vc_i], data_i is stored in FIFO[rx_vc_i].
//   rx_i to a full VC, or rx_vc_i>=NUM_VC, drops the flit with no state change.
// - Read: pop FIFO[v] when data_av_o[v] && data_ack_i[v]. data_ack_i[v] is ignored while data_av_o[v]==0.
// - Write latency: a flit written into an empty FIFO appears at data_o one cycle later; no bypass.
// - Simultaneous push+pop on one VC: both happen and occupancy is unchanged. A full FIFO has credit_o=0, so no push.
// - Pointers wrap modulo BUFFER_SIZE. Occupancy counter spans 0..BUFFER_SIZE; full = (occ==BUFFER_SIZE); empty = (occ==0).
// - Per-VC FSM, one-hot, transitions registered:
//   INIT    -> REQ      when FIFO non-empty
//   REQ     -> HEADER   on req_ack_i[v]; req_o[v]=1 only in REQ
//   HEADER  -> SIZE     on pop
//   SIZE    -> PAYLOAD  on pop, loading flit_cntr<=data_o[v]; if data_o[v]==0, SIZE -> INIT instead (empty packet)
//   PAYLOAD -> INIT     on pop with flit_cntr==1; each pop decrements flit_cntr (FLIT_SIZE bits)
// - data_av_o[v] = state in {HEADER,SIZE,PAYLOAD} && FIFO non-empty. sending_o[v] is the same condition.
// - VCs are fully independent; any set of VCs may request and send in the same cycle.
// - A following packet's header may already be buffered during PAYLOAD; it is not presented until the FSM passes INIT->REQ.
// CONFIGURATION
// - HERMES_VC_BUFFER_STATS_EN defined: adds output occupancy_o [NUM_VC][$clog2(BUFFER_SIZE+1)] giving the live occ per VC.
//   Also adds overflow_o [NUM_VC], a sticky bit set when rx_i targets a full VC (dropped flit) and cleared only by reset.
// - HERMES_VC_BUFFER_STATS_EN undefined: these ports and their logic do not exist; behaviour is otherwise identical.
// TESTING
// - Reset then idle -> credit_o=2'b11, req_o=0, data_av_o=0 with NUM_VC=2.
// - VC0 packet hdr=0x0011, size=3, payload 3 flits; req_ack after 2 cycles; ack held high.
//   Response: req_o[0] 1 cycle after first write, 5 pops, FSM back to INIT, VC1 untouched.
// - Fill VC1 with 8 flits and no ack -> credit_o[1]=0 after 8th write. 9th rx_i on VC1 is dropped; FIFO contents are unchanged.
//   With STATS_EN, overflow_o[1]=1.
// - Interleaved writes VC0/VC1 each cycle, with both packets acked concurrently -> both streams intact and in order per VC.
// - Size flit=0 -> FSM goes SIZE->INIT after 2 pops; the next buffered header raises req_o again the following cycle.
// - Assert rst_ni=0 for 1 cycle mid-PAYLOAD with 4 flits buffered -> next cycle occ=0, credit_o=1, all FSMs INIT, data_av_o=0.

Source files
------------

// File: rtl/hermes_vc_buffer.sv
// hermes_vc_buffer: multi-VC input buffer for a Hermes router port (one circular FIFO + packet FSM per VC).
// Define HERMES_VC_BUFFER_STATS_EN to add per-VC occupancy_o and sticky overflow_o outputs.
module hermes_vc_buffer #(
    parameter int  NUM_VC      = 2,
    parameter int  BUFFER_SIZE = 8,
    parameter int  FLIT_SIZE   = 32,
    localparam int VC_BITS     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int OCC_W       = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             rx_i,
    input  logic [VC_BITS-1:0]               rx_vc_i,
    input  logic [FLIT_SIZE-1:0]             data_i,
    output logic [NUM_VC-1:0]                credit_o,
    output logic [NUM_VC-1:0]                req_o,
    input  logic [NUM_VC-1:0]                req_ack_i,
    output logic [NUM_VC-1:0]                data_av_o,
    input  logic [NUM_VC-1:0]                data_ack_i,
    output logic [NUM_VC-1:0]                sending_o,
    output logic [NUM_VC-1:0][FLIT_SIZE-1:0] data_o
`ifdef HERMES_VC_BUFFER_STATS_EN
    ,
    output logic [NUM_VC-1:0][OCC_W-1:0]     occupancy_o,
    output logic [NUM_VC-1:0]                overflow_o
`endif
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);

    typedef enum logic [4:0] {
        ST_INIT    = 5'b00001,
        ST_REQ     = 5'b00010,
        ST_HEADER  = 5'b00100,
        ST_SIZE    = 5'b01000,
        ST_PAYLOAD = 5'b10000
    } state_e;

    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
        logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
        logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
        logic [OCC_W-1:0]     occ_q, occ_d;
        state_e               state_q, state_d;
        logic [FLIT_SIZE-1:0] flit_cntr_q, flit_cntr_d;
        logic                 sel, full, empty, push, pop, data_av;
        logic [FLIT_SIZE-1:0] head_flit;

        assign sel       = (rx_vc_i == VC_BITS'(gi));
        assign full      = (occ_q == OCC_W'(BUFFER_SIZE));
        assign empty     = (occ_q == '0);
        assign push      = rx_i && sel && !full;
        assign head_flit = mem_q[rd_ptr_q];
        assign data_av   = ((state_q == ST_HEADER) || (state_q == ST_SIZE) ||
                            (state_q == ST_PAYLOAD)) && !empty;
        assign pop       = data_av && data_ack_i[gi];

        // Storage array carries no reset; pointers and occupancy define validity.
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            occ_d    = occ_q;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                occ_d = occ_q + OCC_W'(1);
            end else if (pop && !push) begin
                occ_d = occ_q - OCC_W'(1);
            end
        end

        always_comb begin
            state_d     = state_q;
            flit_cntr_d = flit_cntr_q;
            case (state_q)
                ST_INIT:    if (!empty) state_d = ST_REQ;
                ST_REQ:     if (req_ack_i[gi]) state_d = ST_HEADER;
                ST_HEADER:  if (pop) state_d = ST_SIZE;
                ST_SIZE: begin
                    // A zero size flit closes the packet without a payload phase.
                    if (pop) begin
                        flit_cntr_d = head_flit;
                        state_d     = (head_flit == '0) ? ST_INIT : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (pop) begin
                        flit_cntr_d = flit_cntr_q - FLIT_SIZE'(1);
                        if (flit_cntr_q == FLIT_SIZE'(1)) begin
                            state_d = ST_INIT;
                        end
                    end
                end
                default:    state_d = ST_INIT;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                occ_q       <= '0;
                state_q     <= ST_INIT;
                flit_cntr_q <= '0;
            end else begin
                wr_ptr_q    <= wr_ptr_d;
                rd_ptr_q    <= rd_ptr_d;
                occ_q       <= occ_d;
                state_q     <= state_d;
                flit_cntr_q <= flit_cntr_d;
            end
        end

        assign credit_o[gi]  = !full;
        assign req_o[gi]     = (state_q == ST_REQ);
        assign data_av_o[gi] = data_av;
        assign sending_o[gi] = data_av;
        assign data_o[gi]    = head_flit;

`ifdef HERMES_VC_BUFFER_STATS_EN
        logic overflow_q, overflow_d;

        always_comb begin
            overflow_d = overflow_q;
            if (rx_i && sel && full) begin
                overflow_d = 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                overflow_q <= 1'b0;
            end else begin
                overflow_q <= overflow_d;
            end
        end

        assign occupancy_o[gi] = occ_q;
        assign overflow_o[gi]  = overflow_q;
`endif
    end

endmodule

// File: tb/tb_hermes_vc_buffer.sv
// Scoreboard bench for hermes_vc_buffer: packet-level reference model, randomized traffic, per-VC flit order check.
module tb_hermes_vc_buffer;
    localparam int NV = 2;
    localparam int BS = 8;
    localparam int FW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 rx;
    logic [0:0]           rx_vc;
    logic [FW-1:0]        din;
    logic [NV-1:0]        credit, req, req_ack, data_av, data_ack, sending;
    logic [NV-1:0][FW-1:0] dout;
`ifdef HERMES_VC_BUFFER_STATS_EN
    logic [NV-1:0][3:0]   occ;
    logic [NV-1:0]        ovf;
`endif

    hermes_vc_buffer #(.NUM_VC(NV), .BUFFER_SIZE(BS), .FLIT_SIZE(FW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .rx_vc_i(rx_vc), .data_i(din),
        .credit_o(credit), .req_o(req), .req_ack_i(req_ack),
        .data_av_o(data_av), .data_ack_i(data_ack), .sending_o(sending),
        .data_o(dout)
`ifdef HERMES_VC_BUFFER_STATS_EN
        , .occupancy_o(occ), .overflow_o(ovf)
`endif
    );

    // Reference model: flits waiting to be sent, model FIFO contents, scoreboard of expected pops.
    logic [FW-1:0] src_q[NV][$];
    logic [FW-1:0] mq[NV][$];
    logic [FW-1:0] exp_q[NV][$];
    int     phase[NV];   // 0 idle, 1 requesting, 2 streaming
    int     npop[NV];    // flits popped in the current packet
    longint psize[NV];
    bit     m_ovf[NV];
    int     n_checks = 0;
    int     n_fail = 0;
    bit     mon_en = 0;
    bit     alt_q = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic model_step();
        bit push, pop;
        logic [FW-1:0] f;
        if (!rst_n) begin
            for (int v = 0; v < NV; v++) begin
                mq[v].delete(); exp_q[v].delete();
                phase[v] = 0; npop[v] = 0; psize[v] = 0; m_ovf[v] = 0;
            end
        end else begin
            for (int v = 0; v < NV; v++) begin
                pop  = (phase[v] == 2) && (mq[v].size() > 0) && data_ack[v];
                push = rx && (int'(rx_vc) == v) && (mq[v].size() < BS);
                if (rx && (int'(rx_vc) == v) && (mq[v].size() == BS)) m_ovf[v] = 1;
                case (phase[v])
                    0: if (mq[v].size() > 0) phase[v] = 1;
                    1: if (req_ack[v]) phase[v] = 2;
                    default: if (pop) begin
                        f = mq[v].pop_front();
                        npop[v]++;
                        if (npop[v] == 2) psize[v] = longint'(f);
                        if (npop[v] >= 2 && longint'(npop[v]) == 2 + psize[v]) begin
                            phase[v] = 0;
                            npop[v]  = 0;
                        end
                    end
                endcase
                if (push) begin
                    mq[v].push_back(din);
                    exp_q[v].push_back(din);
                    void'(src_q[v].pop_front());
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compares outputs against the model and pops the scoreboard on every consumed flit.
    initial forever begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            for (int v = 0; v < NV; v++) begin
                bit eav;
                eav = (phase[v] == 2) && (mq[v].size() > 0);
                check($sformatf("credit[%0d]", v), credit[v], mq[v].size() < BS);
                check($sformatf("req[%0d]", v), req[v], phase[v] == 1);
                check($sformatf("data_av[%0d]", v), data_av[v], eav);
                check($sformatf("sending[%0d]", v), sending[v], eav);
`ifdef HERMES_VC_BUFFER_STATS_EN
                check($sformatf("occupancy[%0d]", v), occ[v], mq[v].size());
                check($sformatf("overflow[%0d]", v), ovf[v], m_ovf[v]);
`endif
                if (data_av[v] && data_ack[v]) begin
                    check($sformatf("sb_nonempty[%0d]", v), exp_q[v].size() > 0, 1);
                    if (exp_q[v].size() > 0)
                        check($sformatf("data[%0d]", v), dout[v], exp_q[v].pop_front());
                end
            end
        end
    end

    task automatic add_packet(input int v, input logic [FW-1:0] hdr, input int size);
        src_q[v].push_back(hdr);
        src_q[v].push_back(FW'(size));
        for (int i = 0; i < size; i++) src_q[v].push_back($urandom());
    endtask

    task automatic drive(input int rx_pct, input int rack_pct, input int dack_pct, input bit alt);
        int v;
        @(negedge clk);
        rx  = 1'b0;
        din = $urandom();
        if (alt) begin
            alt_q = ~alt_q;
            v = int'(alt_q);
        end else begin
            v = $urandom_range(0, NV - 1);
        end
        if (src_q[v].size() == 0) v = 1 - v;
        if (src_q[v].size() > 0 && $urandom_range(0, 99) < rx_pct) begin
            rx    = 1'b1;
            rx_vc = 1'(v);
            din   = src_q[v][0];
        end
        for (int k = 0; k < NV; k++) begin
            req_ack[k]  = $urandom_range(0, 99) < rack_pct;
            data_ack[k] = $urandom_range(0, 99) < dack_pct;
        end
    endtask

    function automatic bit idle();
        for (int v = 0; v < NV; v++)
            if (src_q[v].size() != 0 || mq[v].size() != 0 || phase[v] != 0) return 0;
        return 1;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!idle() && n < budget) begin
            drive(100, 100, 100, 0);
            n++;
        end
        drive(0, 0, 0, 0);
        check(name, idle(), 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; rx = 1'b0; rx_vc = '0; din = '0; req_ack = '0; data_ack = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        #3;
        check("reset_credit", credit, 2'b11);
        check("reset_req", req, 2'b00);
        check("reset_data_av", data_av, 2'b00);
        check("reset_sending", sending, 2'b00);

        // Single VC0 packet, grant delayed a few cycles, consumer always ready.
        add_packet(0, 32'h0000_0011, 3);
        repeat (3) drive(100, 0, 100, 0);
        drain("drain_vc0_pkt", 100);

        // Overfill VC1 with no grants: credit drops and extra flits bounce until space returns.
        add_packet(1, 32'h0000_0AA1, 10);
        repeat (12) drive(100, 0, 0, 0);
        #3;
        check("vc1_full_credit", credit, 2'b01);
`ifdef HERMES_VC_BUFFER_STATS_EN
        check("vc1_overflow", ovf, 2'b10);
`endif
        drain("drain_vc1_full", 300);

        // Interleaved writes to both VCs, both granted concurrently.
        add_packet(0, 32'h0000_0B00, 4);
        add_packet(1, 32'h0000_0B01, 4);
        repeat (12) drive(100, 100, 100, 1);
        drain("drain_interleaved", 200);

        // Empty packet followed by a buffered header.
        add_packet(0, 32'h0000_0C00, 0);
        add_packet(0, 32'h0000_0C01, 2);
        repeat (6) drive(100, 100, 100, 0);
        drain("drain_size0", 200);

        // Randomized traffic with random grants and back-pressure.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 6; k++)
                add_packet($urandom_range(0, NV - 1), $urandom(), $urandom_range(0, 6));
            repeat (200) drive(60, 40, 50, 0);
        end
        drain("drain_random", 2000);

        // Reset mid-payload with 4 flits still buffered in VC0.
        add_packet(0, 32'h0000_0D00, 10);
        repeat (6) drive(100, 0, 0, 0);
        @(negedge clk);
        rx = 1'b0; req_ack = 2'b11; data_ack = 2'b01;
        n = 0;
        while (npop[0] < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        data_ack = '0; req_ack = '0;
        #3;
        check("mid_payload_av", data_av[0], 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        src_q[0].delete();
        #3;
        check("post_reset_credit", credit, 2'b11);
        check("post_reset_req", req, 2'b00);
        check("post_reset_data_av", data_av, 2'b00);

        add_packet(0, 32'h0000_0E00, 2);
        drain("drain_after_reset", 200);

        for (int v = 0; v < NV; v++)
            check($sformatf("sb_empty[%0d]", v), exp_q[v].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
